// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the regfile write-back arbiter.
// XLEN falls back to 32 only when the project defines are not already loaded.
`ifndef XLEN
`define XLEN 32
`endif

package wb_pkg;

    localparam int XLEN = `XLEN;

    localparam logic [4:0] ZERO_REG = 5'd0;

    localparam int DEFAULT_DEPTH = 8;

    typedef struct packed {
        logic [4:0]      idx;
        logic [XLEN-1:0] data;
    } wb_entry_t;

    // Width needed to hold an occupancy of 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int COUNT_W = count_width(DEFAULT_DEPTH);

endpackage

// File: rtl/regfile_wb_arbiter_accept_sel.sv
// Fixed-priority grant of up to two nonzero-index sources per cycle.
// Zero-index results are always granted and dropped without using a lane.
module wb_accept_sel
    import wb_pkg::*;
#(
    parameter int N_SRC = 4,
    parameter int CNT_W = 4,
    localparam int SEL_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic [N_SRC-1:0]      src_valid,
    input  logic [N_SRC-1:0][4:0] src_idx,
    input  logic [CNT_W-1:0]      free,
    output logic [N_SRC-1:0]      grant,
    output logic [SEL_W-1:0]      lane0_sel,
    output logic [SEL_W-1:0]      lane1_sel,
    output logic [1:0]            enq_cnt
);

    logic [1:0] limit_s;

    // Lane budget is min(2, free), taken from the registered occupancy only.
    always_comb begin
        if (free >= CNT_W'(2)) begin
            limit_s = 2'd2;
        end else begin
            limit_s = free[1:0];
        end
    end

    // Priority scan, source 0 first; lane0 always receives the older grant.
    always_comb begin
        grant     = '0;
        lane0_sel = '0;
        lane1_sel = '0;
        enq_cnt   = 2'd0;
        for (int i = 0; i < N_SRC; i++) begin
            if (src_valid[i]) begin
                if (src_idx[i] == ZERO_REG) begin
                    grant[i] = 1'b1;
                end else if (enq_cnt < limit_s) begin
                    grant[i] = 1'b1;
                    if (enq_cnt == 2'd0) begin
                        lane0_sel = SEL_W'(i);
                    end else begin
                        lane1_sel = SEL_W'(i);
                    end
                    enq_cnt = enq_cnt + 2'd1;
                end else begin
                    grant[i] = 1'b0;
                end
            end else begin
                grant[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-side front end for the dual-write-port regfile: collects unit results
// into an in-order FIFO and drains up to two hazard-free entries per cycle.
module regfile_wb_arbiter
    import wb_pkg::*;
#(
    parameter int N_SRC = 4,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int XLEN  = wb_pkg::XLEN,
    localparam int CNT_W = count_width(DEPTH),
    localparam int PTR_W = $clog2(DEPTH),
    localparam int SEL_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_SRC-1:0]         src_valid,
    input  logic [N_SRC-1:0][4:0]    src_idx,
    input  logic [N_SRC-1:0][XLEN-1:0] src_data,
    output logic [N_SRC-1:0]         src_ready,
    output logic                     wra_en,
    output logic [4:0]               wra_idx,
    output logic [XLEN-1:0]          wra_data,
    output logic                     wrb_en,
    output logic [4:0]               wrb_idx,
    output logic [XLEN-1:0]          wrb_data,
    output logic [CNT_W-1:0]         count,
    output logic                     empty,
    output logic                     full
);

    wb_entry_t          mem_r [DEPTH];
    logic [PTR_W-1:0]   head_r;
    logic [PTR_W-1:0]   tail_r;
    logic [CNT_W-1:0]   count_r;

    logic [CNT_W-1:0]   free_s;
    logic [N_SRC-1:0]   grant_s;
    logic [SEL_W-1:0]   lane0_sel_s;
    logic [SEL_W-1:0]   lane1_sel_s;
    logic [1:0]         sel_cnt_s;
    logic [1:0]         enq_s;
    logic [1:0]         drain_s;
    wb_entry_t          lane0_entry_s;
    wb_entry_t          lane1_entry_s;
    wb_entry_t          head_entry_s;
    wb_entry_t          next_entry_s;

    assign free_s = CNT_W'(DEPTH) - count_r;

    wb_accept_sel #(
        .N_SRC (N_SRC),
        .CNT_W (CNT_W)
    ) u_accept_sel (
        .src_valid (src_valid),
        .src_idx   (src_idx),
        .free      (free_s),
        .grant     (grant_s),
        .lane0_sel (lane0_sel_s),
        .lane1_sel (lane1_sel_s),
        .enq_cnt   (sel_cnt_s)
    );

    // Nothing is accepted while reset is held low.
    always_comb begin
        if (reset) begin
            src_ready = grant_s;
            enq_s     = sel_cnt_s;
        end else begin
            src_ready = '0;
            enq_s     = 2'd0;
        end
    end

    assign lane0_entry_s = '{idx: src_idx[lane0_sel_s], data: src_data[lane0_sel_s]};
    assign lane1_entry_s = '{idx: src_idx[lane1_sel_s], data: src_data[lane1_sel_s]};

    // Drain from the registered head; a same-index pair is split so the younger value lands last.
    always_comb begin
        head_entry_s = mem_r[head_r];
        next_entry_s = mem_r[head_r + PTR_W'(1)];
        wra_en   = 1'b0;
        wra_idx  = 5'd0;
        wra_data = '0;
        wrb_en   = 1'b0;
        wrb_idx  = 5'd0;
        wrb_data = '0;
        drain_s  = 2'd0;
        if (reset && (count_r != CNT_W'(0))) begin
            wra_en   = 1'b1;
            wra_idx  = head_entry_s.idx;
            wra_data = head_entry_s.data;
            drain_s  = 2'd1;
            if ((count_r >= CNT_W'(2)) && (next_entry_s.idx != head_entry_s.idx)) begin
                wrb_en   = 1'b1;
                wrb_idx  = next_entry_s.idx;
                wrb_data = next_entry_s.data;
                drain_s  = 2'd2;
            end else begin
                wrb_en   = 1'b0;
            end
        end else begin
            drain_s = 2'd0;
        end
    end

    // Entry storage; slots are written in acceptance order starting at tail.
    always_ff @(posedge clk) begin
        if (enq_s != 2'd0) begin
            mem_r[tail_r] <= lane0_entry_s;
        end
        if (enq_s == 2'd2) begin
            mem_r[tail_r + PTR_W'(1)] <= lane1_entry_s;
        end
    end

    // Pointer and occupancy update; reset discards everything buffered.
    always_ff @(posedge clk) begin
        if (!reset) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else begin
            head_r  <= head_r + PTR_W'(drain_s);
            tail_r  <= tail_r + PTR_W'(enq_s);
            count_r <= count_r + CNT_W'(enq_s) - CNT_W'(drain_s);
        end
    end

    assign count = count_r;
    assign empty = (count_r == CNT_W'(0));
    assign full  = (count_r == CNT_W'(DEPTH));

endmodule
